// File: rtl/pwm_ramp.sv
// Duty-cycle slew limiter for a PWM generator: ramps ton toward an accepted target at period boundaries.
// Optional target clamping to DMAX is enabled by defining PWM_RAMP_CLAMP_EN.
module pwm_ramp #(
  parameter int T    = 1000,
  parameter int STEP = 1,
  parameter int DIV  = 1,
  parameter int DMAX = T
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(T)-1:0] target,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic                 estop,
  output logic [$clog2(T)-1:0] ton,
  output logic                 period_tick,
  output logic                 settled
);

  localparam int W      = $clog2(T);
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STEP_C = (STEP > T) ? T : STEP;
  localparam int DMAX_C = (DMAX > T) ? T : DMAX;

  localparam logic [W-1:0]  CNT_LAST = W'(T - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W:0]    STEP_X   = (W + 1)'(STEP_C);
  localparam logic [W-1:0]  STEP_W   = STEP_X[W-1:0];
  localparam logic [W:0]    DMAX_X   = (W + 1)'(DMAX_C);

`ifdef PWM_RAMP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  typedef enum logic [1:0] {
    SETTLED,
    UP,
    DOWN
  } dir_t;

  logic [W-1:0]  cnt_reg, cnt_next;
  logic [DW-1:0] divcnt_reg, divcnt_next;
  logic [W-1:0]  ton_reg, ton_next;
  logic [W-1:0]  tgt_reg, tgt_next;
  logic [W-1:0]  pend_reg, pend_next;
  logic          pend_vld_reg, pend_vld_next;

  logic          boundary;
  logic          accept;
  logic [W-1:0]  eff;
  logic [W-1:0]  gap;
  logic          close;
  logic [W-1:0]  stepped;
  logic [W-1:0]  stored;
  dir_t          dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      divcnt_reg   <= '0;
      ton_reg      <= '0;
      tgt_reg      <= '0;
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      divcnt_reg   <= divcnt_next;
      ton_reg      <= ton_next;
      tgt_reg      <= tgt_next;
      pend_reg     <= pend_next;
      pend_vld_reg <= pend_vld_next;
    end
  end

  assign target_ready = !pend_vld_reg && !estop && !rst;
  assign accept       = target_valid && target_ready;
  assign boundary     = (cnt_reg == CNT_LAST);
  assign period_tick  = boundary;
  assign settled      = (ton_reg == tgt_reg) && !pend_vld_reg;
  assign ton          = ton_reg;

  // A pending target takes effect at the very boundary that promotes it.
  assign eff = pend_vld_reg ? pend_reg : tgt_reg;

  always_comb begin
    dir     = SETTLED;
    gap     = '0;
    stepped = ton_reg;
    if (ton_reg < eff) begin
      dir = UP;
      gap = eff - ton_reg;
    end else if (ton_reg > eff) begin
      dir = DOWN;
      gap = ton_reg - eff;
    end
    // Landing on eff when within one step avoids any overshoot or rail wrap.
    close = ({1'b0, gap} <= STEP_X);
    case (dir)
      UP:      stepped = close ? eff : ton_reg + STEP_W;
      DOWN:    stepped = close ? eff : ton_reg - STEP_W;
      default: stepped = ton_reg;
    endcase
  end

  always_comb begin
    stored = target;
    if (CLAMP && ({1'b0, target} > DMAX_X)) begin
      stored = DMAX_X[W-1:0];
    end
  end

  always_comb begin
    cnt_next      = boundary ? '0 : cnt_reg + W'(1);
    divcnt_next   = divcnt_reg;
    ton_next      = ton_reg;
    tgt_next      = tgt_reg;
    pend_next     = pend_reg;
    pend_vld_next = pend_vld_reg;
    if (estop) begin
      ton_next      = '0;
      tgt_next      = '0;
      pend_vld_next = 1'b0;
      divcnt_next   = '0;
    end else begin
      if (accept) begin
        pend_next     = stored;
        pend_vld_next = 1'b1;
      end
      if (boundary) begin
        if (pend_vld_reg) begin
          tgt_next      = pend_reg;
          pend_vld_next = 1'b0;
        end
        if (divcnt_reg == DIV_LAST) begin
          divcnt_next = '0;
          ton_next    = stepped;
        end else begin
          divcnt_next = divcnt_reg + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp (T=10, STEP=2): table-driven cycle vectors plus reset and DIV=3 sequences.
module tb_pwm_ramp;

`ifdef PWM_RAMP_CLAMP_EN
  localparam int CT = 6;
`else
  localparam int CT = 9;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] target;
  logic       target_valid;
  logic       target_ready;
  logic       estop;
  logic [3:0] ton;
  logic       period_tick;
  logic       settled;

  logic [3:0] target3;
  logic       target_valid3;
  logic       target_ready3;
  logic       estop3;
  logic [3:0] ton3;
  logic       period_tick3;
  logic       settled3;

  int checks = 0;
  int errors = 0;

  pwm_ramp #(.T(10), .STEP(2), .DIV(1), .DMAX(6)) dut (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .estop(estop), .ton(ton),
    .period_tick(period_tick), .settled(settled)
  );

  pwm_ramp #(.T(10), .STEP(2), .DIV(3), .DMAX(6)) dut3 (
    .clk(clk), .rst(rst), .target(target3), .target_valid(target_valid3),
    .target_ready(target_ready3), .estop(estop3), .ton(ton3),
    .period_tick(period_tick3), .settled(settled3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         adv;
    logic [3:0] tgt;
    logic       vld;
    logic       est;
    int         ton;
    int         rdy;
    int         stl;
    int         ptk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int adv, int tg, bit v, bit e, int t, int r, int s, int p);
    vec_t x;
    x.adv = adv; x.tgt = 4'(tg); x.vld = v; x.est = e;
    x.ton = t; x.rdy = r; x.stl = s; x.ptk = p;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int ton3_exp[9] = '{0, 0, 2, 2, 2, 4, 4, 4, 6};

  initial begin
    // adv = cycles to advance, then inputs are applied and outputs checked in that cycle
    vecs.push_back(mk( 0, 7, 1, 0, 0, 1, 1, 0));  // c0: present target 7
    vecs.push_back(mk( 1, 7, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 8, 7, 0, 0, 0, 0, 0, 1));  // c9 boundary
    vecs.push_back(mk( 1, 7, 0, 0, 2, 1, 0, 0));  // c10
    vecs.push_back(mk(10, 7, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk(10, 7, 0, 0, 6, 1, 0, 0));
    vecs.push_back(mk(10, 0, 1, 0, 7, 1, 1, 0));  // c40 settled at 7, send 0
    vecs.push_back(mk( 1, 5, 1, 0, 7, 0, 0, 0));  // hold target 5 valid
    vecs.push_back(mk( 8, 5, 1, 0, 7, 0, 0, 1));
    vecs.push_back(mk( 1, 5, 1, 0, 5, 1, 0, 0));  // c50 slot free again
    vecs.push_back(mk( 1, 5, 0, 0, 5, 0, 0, 0));  // 5 accepted at c50
    vecs.push_back(mk( 9, 4, 1, 0, 5, 1, 1, 0));  // c60 settled at 5
    vecs.push_back(mk( 1, 4, 0, 0, 5, 0, 0, 0));
    vecs.push_back(mk( 9, 8, 1, 0, 4, 1, 1, 0));  // c70 ton 4, send 8
    vecs.push_back(mk( 1, 8, 0, 1, 4, 0, 0, 0));  // c71 8 pending, raise estop
    vecs.push_back(mk( 1, 3, 1, 1, 0, 0, 1, 0));  // c72 during estop
    vecs.push_back(mk( 1, 3, 0, 0, 0, 1, 1, 0));  // c73 no accept during estop
    vecs.push_back(mk( 6, 4, 1, 0, 0, 1, 1, 1));  // c79 target 4 at boundary
    vecs.push_back(mk( 1, 4, 0, 0, 0, 0, 0, 0));  // c80 unchanged, 8 discarded
    vecs.push_back(mk( 9, 4, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 1, 4, 0, 0, 2, 1, 0, 0));  // c90
    vecs.push_back(mk(10, 9, 1, 0, 4, 1, 1, 0));  // c100 send 9
    vecs.push_back(mk( 1, 9, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk( 9, 9, 0, 0, 6, 1, (CT == 6) ? 1 : 0, 0));
    vecs.push_back(mk(10, 9, 0, 0, (CT == 6) ? 6 : 8, 1, (CT == 6) ? 1 : 0, 0));
    vecs.push_back(mk(10, 1, 1, 0, CT, 1, 1, 0));  // c130 send 1
    vecs.push_back(mk( 1, 1, 0, 0, CT, 0, 0, 0));
    vecs.push_back(mk( 9, 1, 0, 0, CT - 2, 1, 0, 0));  // c140 reversed

    rst = 1'b1;
    target = '0; target_valid = 1'b0; estop = 1'b0;
    target3 = '0; target_valid3 = 1'b0; estop3 = 1'b0;
    repeat (2) tick();
    check("reset_ton", int'(ton), 0);
    check("reset_ready", int'(target_ready), 0);
    check("reset_settled", int'(settled), 1);
    check("reset_tick", int'(period_tick), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].adv) tick();
      target       = vecs[i].tgt;
      target_valid = vecs[i].vld;
      estop        = vecs[i].est;
      #1;
      $display("vec %0d: ton=%0d ready=%0d settled=%0d tick=%0d", i, ton, target_ready,
               settled, period_tick);
      check($sformatf("vec%0d_ton", i), int'(ton), vecs[i].ton);
      check($sformatf("vec%0d_ready", i), int'(target_ready), vecs[i].rdy);
      check($sformatf("vec%0d_settled", i), int'(settled), vecs[i].stl);
      check($sformatf("vec%0d_tick", i), int'(period_tick), vecs[i].ptk);
    end

    // Reset mid-ramp, between clock edges
    repeat (3) tick();
    check("pre_rst_ton", int'(ton), CT - 2);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: ton=%0d cnt=%0d settled=%0d", ton, dut.cnt_reg, settled);
    check("async_rst_ton", int'(ton), 0);
    check("async_rst_cnt", int'(dut.cnt_reg), 0);
    check("async_rst_settled", int'(settled), 1);
    check("async_rst_ready", int'(target_ready), 0);

    // DIV=3 ramp from 0 to 6
    tick();
    rst = 1'b0;
    target = '0; target_valid = 1'b0;
    target3 = 4'd6; target_valid3 = 1'b1;
    #1;
    check("div3_ready_c0", int'(target_ready3), 1);
    tick();
    target_valid3 = 1'b0;
    #1;
    check("div3_ready_c1", int'(target_ready3), 0);
    repeat (8) tick();
    for (int k = 0; k < 9; k++) begin
      repeat (10) tick();
      $display("div3 cycle %0d: ton=%0d", (k + 1) * 10, ton3);
      check($sformatf("div3_ton_c%0d", (k + 1) * 10), int'(ton3), ton3_exp[k]);
    end
    check("div3_settled", int'(settled3), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
